muldiv_ctrl: RTL and testbench

- Sequencer for an iterative 32-bit multiply/divide unit and the architectural HI/LO registers, attached to the EXE stage.
- Replaces the constant EXE `ready`. Holds the EXE stage while a MULT/MULTU/DIV/DIVU iterates.
- Commits HI/LO only when the instruction leaves EXE.
- Serves MTHI/MTLO/MFHI/MFLO in a single cycle.

---
 rtl/muldiv_ctrl_if.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// EXE-stage <-> multiply/divide sequencer bundle.
// The EXE pipeline side drives the request and operands; the sequencer answers
// with ready/busy, the MF read data and the architectural HI/LO values.
interface muldiv_ctrl_if #(
  parameter int XLEN = 32
);
  logic            md_valid_in;
  logic [3:0]      md_op_in;
  logic [XLEN-1:0] md_src0_in;
  logic [XLEN-1:0] md_src1_in;
  logic            mem_allowin_in;
  logic            flush_in;
  logic            md_ready_out;
  logic            md_busy_out;
  logic [XLEN-1:0] md_rdata_out;
  logic [XLEN-1:0] hi_out;
  logic [XLEN-1:0] lo_out;

  modport master (
    output md_valid_in,
    output md_op_in,
    output md_src0_in,
    output md_src1_in,
    output mem_allowin_in,
    output flush_in,
    input  md_ready_out,
    input  md_busy_out,
    input  md_rdata_out,
    input  hi_out,
    input  lo_out
  );

  modport slave (
    input  md_valid_in,
    input  md_op_in,
    input  md_src0_in,
    input  md_src1_in,
    input  mem_allowin_in,
    input  flush_in,
    output md_ready_out,
    output md_busy_out,
    output md_rdata_out,
    output hi_out,
    output lo_out
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide sequencer with the architectural HI/LO registers.
// Multiplies are shift-add and divides are restoring, one bit per cycle, both
// on unsigned magnitudes with a sign fix-up folded into the last iteration.
// The result waits in DONE and is written to HI/LO only when the instruction
// leaves EXE, so a following MFHI/MFLO always reads the committed value.
module muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave md
);

  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Magnitude of a possibly signed operand; the most negative value maps to
  // itself, which is the correct magnitude once read as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v,
                                          input logic                   use_sign);
    logic [XLEN-1:0] u;
    u = v;
    return (use_sign && v < 0) ? -u : u;
  endfunction

  // Conditional two's-complement negation of a single-word result.
  function automatic logic [XLEN-1:0] sign_fix_w(input logic [XLEN-1:0] v,
                                                 input logic            neg);
    return neg ? -v : v;
  endfunction

  // Conditional two's-complement negation of the double-word product.
  function automatic logic [2*XLEN-1:0] sign_fix_d(input logic [2*XLEN-1:0] v,
                                                   input logic              neg);
    return neg ? -v : v;
  endfunction

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [XLEN-1:0]       hi_q;
  logic [XLEN-1:0]       lo_q;
  // Multiplicand (MUL) or divisor (DIV) magnitude, fixed for the whole op.
  logic [XLEN-1:0]       opb_q;
  // MUL: {partial product high, multiplier/product low}.
  // DIV: {partial remainder, dividend bits shifting out / quotient shifting in}.
  logic [2*XLEN-1:0]     acc_q;
  logic                  neg_res_q;
  logic                  neg_rem_q;

  logic                  is_md;
  logic                  is_mul;
  logic                  op_signed;
  logic                  start;
  logic                  commit;
  logic                  mt_wr;
  logic signed [XLEN-1:0] src0_s;
  logic signed [XLEN-1:0] src1_s;
  logic                  src0_neg;
  logic                  src1_neg;
  logic [XLEN-1:0]       src0_mag;
  logic [XLEN-1:0]       src1_mag;

  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;
  logic [XLEN:0]         div_part;
  logic                  div_ok;
  logic [XLEN-1:0]       div_rem;
  logic [2*XLEN-1:0]     div_next;
  logic [2*XLEN-1:0]     step_res;
  logic [2*XLEN-1:0]     final_res;

  assign is_md     = (md.md_op_in >= OP_MULT) && (md.md_op_in <= OP_DIVU);
  assign is_mul    = (md.md_op_in == OP_MULT) || (md.md_op_in == OP_MULTU);
  assign op_signed = (md.md_op_in == OP_MULT) || (md.md_op_in == OP_DIV);
  assign start     = (state == S_IDLE) && md.md_valid_in && is_md && !md.flush_in;
  assign commit    = (state == S_DONE) && md.mem_allowin_in && !md.flush_in;
  assign mt_wr     = (state == S_IDLE) && md.md_valid_in && md.mem_allowin_in &&
                     !md.flush_in &&
                     ((md.md_op_in == OP_MTHI) || (md.md_op_in == OP_MTLO));

  assign src0_s    = md.md_src0_in;
  assign src1_s    = md.md_src1_in;
  assign src0_neg  = op_signed && (src0_s < 0);
  assign src1_neg  = op_signed && (src1_s < 0);
  assign src0_mag  = mag(src0_s, op_signed);
  assign src1_mag  = mag(src1_s, op_signed);

  // One iteration of the shift-add multiplier or the restoring divider, plus
  // the signed result that the final iteration hands to DONE.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Partial remainder with the next dividend bit shifted in is one bit
    // wider than a word; the subtraction only happens when it cannot borrow,
    // so the restored remainder always fits back in a word.
    div_part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ok   = div_part >= {1'b0, opb_q};
    div_rem  = div_part[XLEN-1:0] - opb_q;
    div_next = div_ok ? {div_rem, acc_q[XLEN-2:0], 1'b1}
                      : {acc_q[2*XLEN-2:0], 1'b0};

    step_res = (state == S_MUL) ? mul_next : div_next;

    if (state == S_MUL) begin
      final_res = sign_fix_d(step_res, neg_res_q);
    end else begin
      final_res = {sign_fix_w(step_res[2*XLEN-1:XLEN], neg_rem_q),
                   sign_fix_w(step_res[XLEN-1:0], neg_res_q)};
    end
  end

  // Sequencer state and iteration counter; flush wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (md.flush_in) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= is_mul ? S_MUL : S_DIV;
            cnt   <= '0;
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (commit) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Operand capture on start, then one datapath step per iteration cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      opb_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (start) begin
      neg_res_q <= src0_neg ^ src1_neg;
      neg_rem_q <= src0_neg;
      if (is_mul) begin
        opb_q <= src0_mag;
        acc_q <= {{XLEN{1'b0}}, src1_mag};
      end else begin
        opb_q <= src1_mag;
        acc_q <= {{XLEN{1'b0}}, src0_mag};
      end
    end else if (!md.flush_in && ((state == S_MUL) || (state == S_DIV))) begin
      acc_q <= (cnt == CNT_LAST) ? final_res : step_res;
    end
  end

  // Architectural HI/LO: written by a commit leaving EXE or by MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= acc_q[2*XLEN-1:XLEN];
      lo_q <= acc_q[XLEN-1:0];
    end else if (mt_wr) begin
      if (md.md_op_in == OP_MTHI) begin
        hi_q <= md.md_src0_in;
      end else begin
        lo_q <= md.md_src0_in;
      end
    end
  end

  // Single-cycle MFHI/MFLO read path.
  always_comb begin
    md.md_rdata_out = '0;
    if (md.md_op_in == OP_MFHI) begin
      md.md_rdata_out = hi_q;
    end else if (md.md_op_in == OP_MFLO) begin
      md.md_rdata_out = lo_q;
    end
  end

  assign md.md_ready_out = ((state == S_IDLE) && !(md.md_valid_in && is_md)) ||
                           (state == S_DONE);
  assign md.md_busy_out  = (state == S_MUL) || (state == S_DIV);
  assign md.hi_out       = hi_q;
  assign md.lo_out       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases plus randomized ops checked against an
// arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.XLEN(32)) md_bus ();

  muldiv_ctrl #(.XLEN(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hi   = '0;
  logic [31:0] exp_lo   = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // HI/LO an op should produce, from plain 64-bit arithmetic and the sign rules.
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] h, output logic [31:0] l);
    logic [63:0] p;
    logic        sa, sb;
    logic [31:0] ua, ub, q, r;
    p = '0;
    case (op)
      4'd1: p = 64'($signed(a)) * 64'($signed(b));
      4'd2: p = {32'd0, a} * {32'd0, b};
      default: begin
        sa = (op == 4'd3) && a[31];
        sb = (op == 4'd3) && b[31];
        ua = sa ? -a : a;
        ub = sb ? -b : b;
        if (ub == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = ua;
        end else begin
          q = ua / ub;
          r = ua % ub;
        end
        if (sa ^ sb) q = -q;
        if (sa) r = -r;
        p = {r, q};
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endtask

  task automatic idle_inputs();
    md_bus.md_valid_in    = 1'b0;
    md_bus.md_op_in       = 4'd0;
    md_bus.md_src0_in     = '0;
    md_bus.md_src1_in     = '0;
    md_bus.mem_allowin_in = 1'b1;
    md_bus.flush_in       = 1'b0;
  endtask

  // Issue one MULT/MULTU/DIV/DIVU. hold = DONE cycles with MEM stalled,
  // flush_cyc = iteration cycle to flush in (-1 none), flush_commit = flush
  // in the commit cycle.
  task automatic md_run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int hold, input int flush_cyc, input bit flush_commit);
    int lat;
    @(negedge clk);
    md_bus.md_valid_in    = 1'b1;
    md_bus.md_op_in       = op;
    md_bus.md_src0_in     = a;
    md_bus.md_src1_in     = b;
    md_bus.mem_allowin_in = (hold == 0);
    md_bus.flush_in       = 1'b0;
    #1 check_val("ready_start", 32'(md_bus.md_ready_out), 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      md_bus.md_src0_in = $urandom;
      md_bus.md_src1_in = $urandom;
      #1;
      if (lat == 1) check_val("busy_iter", 32'(md_bus.md_busy_out), 32'd1);
      if (lat == flush_cyc) begin
        md_bus.flush_in = 1'b1;
        @(negedge clk);
        md_bus.flush_in    = 1'b0;
        md_bus.md_valid_in = 1'b0;
        #1;
        check_val("flush_ready", 32'(md_bus.md_ready_out), 32'd1);
        check_val("flush_busy", 32'(md_bus.md_busy_out), 32'd0);
        check_val("flush_hi", md_bus.hi_out, exp_hi);
        check_val("flush_lo", md_bus.lo_out, exp_lo);
        idle_inputs();
        return;
      end
    end while (!md_bus.md_ready_out && lat < 60);
    check_val("latency", 32'(lat), 32'd33);
    check_val("done_busy", 32'(md_bus.md_busy_out), 32'd0);
    check_val("done_hi_old", md_bus.hi_out, exp_hi);
    check_val("done_lo_old", md_bus.lo_out, exp_lo);
    for (int h = 0; h < hold; h++) begin
      check_val("hold_ready", 32'(md_bus.md_ready_out), 32'd1);
      check_val("hold_hi", md_bus.hi_out, exp_hi);
      check_val("hold_lo", md_bus.lo_out, exp_lo);
      @(negedge clk);
      md_bus.md_src0_in = $urandom;
      #1;
    end
    md_bus.mem_allowin_in = 1'b1;
    md_bus.flush_in       = flush_commit;
    @(negedge clk);
    md_bus.md_valid_in = 1'b0;
    md_bus.flush_in    = 1'b0;
    #1;
    if (!flush_commit) begin
      exp_hi = eh;
      exp_lo = el;
    end
    check_val("commit_hi", md_bus.hi_out, exp_hi);
    check_val("commit_lo", md_bus.lo_out, exp_lo);
    check_val("after_busy", 32'(md_bus.md_busy_out), 32'd0);
    check_val("after_ready", 32'(md_bus.md_ready_out), 32'd1);
    md_bus.md_valid_in = 1'b1;
    md_bus.md_op_in    = 4'd7;
    #1 check_val("mfhi_after", md_bus.md_rdata_out, exp_hi);
    md_bus.md_op_in    = 4'd8;
    #1 check_val("mflo_after", md_bus.md_rdata_out, exp_lo);
    idle_inputs();
  endtask

  // MTHI/MTLO (optionally flushed), then read back with MFHI/MFLO next cycle.
  task automatic mt_write(input logic [3:0] op, input logic [31:0] v, input bit fl);
    @(negedge clk);
    md_bus.md_valid_in    = 1'b1;
    md_bus.md_op_in       = op;
    md_bus.md_src0_in     = v;
    md_bus.mem_allowin_in = 1'b1;
    md_bus.flush_in       = fl;
    #1 check_val("mt_ready", 32'(md_bus.md_ready_out), 32'd1);
    @(negedge clk);
    md_bus.flush_in   = 1'b0;
    md_bus.md_op_in   = (op == 4'd5) ? 4'd7 : 4'd8;
    md_bus.md_src0_in = $urandom;
    if (!fl) begin
      if (op == 4'd5) exp_hi = v;
      else            exp_lo = v;
    end
    #1;
    check_val("mf_rdata", md_bus.md_rdata_out, (op == 4'd5) ? exp_hi : exp_lo);
    check_val("mt_hi", md_bus.hi_out, exp_hi);
    check_val("mt_lo", md_bus.lo_out, exp_lo);
    idle_inputs();
  endtask

  // Codes outside 1..8 behave like no operation.
  task automatic bad_op();
    @(negedge clk);
    md_bus.md_valid_in = 1'b1;
    md_bus.md_op_in    = 4'($urandom_range(9, 15));
    md_bus.md_src0_in  = $urandom;
    #1;
    check_val("badop_ready", 32'(md_bus.md_ready_out), 32'd1);
    check_val("badop_rdata", md_bus.md_rdata_out, 32'd0);
    @(negedge clk);
    #1;
    check_val("badop_busy", 32'(md_bus.md_busy_out), 32'd0);
    check_val("badop_hi", md_bus.hi_out, exp_hi);
    check_val("badop_lo", md_bus.lo_out, exp_lo);
    idle_inputs();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, eh, el;
    logic [3:0]  op;
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_hi", md_bus.hi_out, 32'd0);
    check_val("rst_lo", md_bus.lo_out, 32'd0);
    check_val("rst_busy", 32'(md_bus.md_busy_out), 32'd0);
    check_val("rst_ready", 32'(md_bus.md_ready_out), 32'd1);
    check_val("rst_rdata", md_bus.md_rdata_out, 32'd0);
    rst = 1'b0;

    md_run(4'd1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, -1, 1'b0);
    md_run(4'd4, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 0, -1, 1'b0);
    md_run(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, -1, 1'b0);
    md_run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, -1, 1'b0);
    md_run(4'd4, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 0, -1, 1'b0);
    md_run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, -1, 1'b0);
    md_run(4'd1, 32'd7, 32'd6, 32'h0000_0000, 32'h0000_002A, 4, -1, 1'b0);
    md_run(4'd1, 32'd123, 32'd456, 32'd0, 32'd0, 0, 10, 1'b0);
    md_run(4'd4, 32'd9, 32'd2, 32'd0, 32'd0, 0, -1, 1'b1);

    mt_write(4'd5, 32'h1234_5678, 1'b0);
    mt_write(4'd6, 32'hCAFE_F00D, 1'b0);
    mt_write(4'd6, 32'hDEAD_BEEF, 1'b1);
    bad_op();

    // Reset in the middle of a divide discards it and clears HI/LO.
    @(negedge clk);
    md_bus.md_valid_in = 1'b1;
    md_bus.md_op_in    = 4'd3;
    md_bus.md_src0_in  = 32'd1000;
    md_bus.md_src1_in  = 32'd3;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    md_bus.md_valid_in = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check_val("rstdiv_hi", md_bus.hi_out, exp_hi);
    check_val("rstdiv_lo", md_bus.lo_out, exp_lo);
    check_val("rstdiv_busy", 32'(md_bus.md_busy_out), 32'd0);
    check_val("rstdiv_ready", 32'(md_bus.md_ready_out), 32'd1);
    idle_inputs();

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: begin
          op = 4'($urandom_range(1, 4));
          a  = pick_operand();
          b  = pick_operand();
          ref_model(op, a, b, eh, el);
          md_run(op, a, b, eh, el, $urandom_range(0, 2), -1, 1'b0);
        end
        4:       mt_write(4'($urandom_range(5, 6)), $urandom, 1'($urandom_range(0, 1)));
        default: bad_op();
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
